tt_um_custom_alu: RTL and testbench

// - 8-bit registered ALU for a Tiny Tapeout tile; top-level user project wrapper.
// - Operands A/B and opcode arrive byte-serially on ui_in under a 2-bit command on uio_in.
// - Result (or operand readback) is driven on uo_out; Z/C/N/V flags on uio_out[7:4].

---
 rtl/customalu_pkg.sv | 54 +++++
 rtl/customalu_core.sv | 117 +++++++++++
 rtl/tt_um_custom_alu.sv | 81 ++++++++
 tb/tb_tt_um_custom_alu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/customalu_pkg.sv
// Shared encodings for the custom ALU tile: opcodes, commands, output
// selects, flag bit positions and signed-overflow helpers.
package customalu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ASR  = 4'h8,
        OP_ROL  = 4'h9,
        OP_ROR  = 4'hA,
        OP_MUL  = 4'hB,
        OP_INC  = 4'hC,
        OP_DEC  = 4'hD,
        OP_CMP  = 4'hE,
        OP_PASS = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'b00,
        CMD_LOAD_A = 2'b01,
        CMD_LOAD_B = 2'b10,
        CMD_EXEC   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        SEL_RES_LO = 2'b00,
        SEL_RES_HI = 2'b01,
        SEL_A      = 2'b10,
        SEL_B      = 2'b11
    } sel_e;

    // Flag nibble is {Z,C,N,V}, MSB first.
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    function automatic logic add_ovf(input logic [7:0] x, input logic [7:0] y,
                                     input logic [7:0] r);
        return (x[7] == y[7]) && (r[7] != x[7]);
    endfunction

    function automatic logic sub_ovf(input logic [7:0] x, input logic [7:0] y,
                                     input logic [7:0] r);
        return (x[7] != y[7]) && (r[7] != x[7]);
    endfunction

endpackage

// File: rtl/customalu_core.sv
// Combinational ALU datapath: computes the next 16-bit result and the
// {Z,C,N,V} flags from the operands, the opcode and the current result.
module customalu_core
    import customalu_pkg::*;
(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  op_e         op,
    input  logic [15:0] res_old,
    output logic [15:0] res,
    output logic [3:0]  flags
);

    logic [8:0]  sum_s;
    logic [8:0]  diff_s;
    logic [8:0]  inc_s;
    logic [8:0]  dec_s;
    logic [15:0] prod_s;
    logic [7:0]  r8_s;
    logic        z_s;
    logic        c_s;
    logic        n_s;
    logic        v_s;

    // Bit 8 of the 9-bit sums is carry out; for the differences it is borrow.
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};
    assign inc_s  = {1'b0, a} + 9'd1;
    assign dec_s  = {1'b0, a} - 9'd1;
    assign prod_s = {8'h00, a} * {8'h00, b};

    // Per-opcode 8-bit result, carry and overflow.
    always_comb begin
        r8_s = 8'h00;
        c_s  = 1'b0;
        v_s  = 1'b0;
        case (op)
            OP_ADD: begin
                r8_s = sum_s[7:0];
                c_s  = sum_s[8];
                v_s  = add_ovf(a, b, sum_s[7:0]);
            end
            OP_SUB, OP_CMP: begin
                r8_s = diff_s[7:0];
                c_s  = diff_s[8];
                v_s  = sub_ovf(a, b, diff_s[7:0]);
            end
            OP_AND:  r8_s = a & b;
            OP_OR:   r8_s = a | b;
            OP_XOR:  r8_s = a ^ b;
            OP_NOT:  r8_s = ~a;
            OP_SHL: begin
                r8_s = {a[6:0], 1'b0};
                c_s  = a[7];
            end
            OP_SHR: begin
                r8_s = {1'b0, a[7:1]};
                c_s  = a[0];
            end
            OP_ASR: begin
                r8_s = {a[7], a[7:1]};
                c_s  = a[0];
            end
            OP_ROL: begin
                r8_s = {a[6:0], a[7]};
                c_s  = a[7];
            end
            OP_ROR: begin
                r8_s = {a[0], a[7:1]};
                c_s  = a[0];
            end
            OP_MUL: begin
                r8_s = prod_s[7:0];
                c_s  = |prod_s[15:8];
            end
            OP_INC: begin
                r8_s = inc_s[7:0];
                c_s  = inc_s[8];
                v_s  = add_ovf(a, 8'h01, inc_s[7:0]);
            end
            OP_DEC: begin
                r8_s = dec_s[7:0];
                c_s  = dec_s[8];
                v_s  = sub_ovf(a, 8'h01, dec_s[7:0]);
            end
            OP_PASS: r8_s = b;
            default: begin
                r8_s = 8'h00;
                c_s  = 1'b0;
                v_s  = 1'b0;
            end
        endcase
    end

    // MUL judges Z/N on the full product; CMP keeps the old result.
    always_comb begin
        res = 16'h0000;
        z_s = 1'b0;
        n_s = 1'b0;
        if (op == OP_MUL) begin
            res = prod_s;
            z_s = (prod_s == 16'h0000);
            n_s = prod_s[15];
        end else if (op == OP_CMP) begin
            res = res_old;
            z_s = (r8_s == 8'h00);
            n_s = r8_s[7];
        end else begin
            res = {8'h00, r8_s};
            z_s = (r8_s == 8'h00);
            n_s = r8_s[7];
        end
    end

    assign flags = {z_s, c_s, n_s, v_s};

endmodule

// File: rtl/tt_um_custom_alu.sv
// Tiny Tapeout wrapper for the custom ALU: operand/result/flag registers,
// command decode on uio_in[1:0] and the output-select mux.
module tt_um_custom_alu
    import customalu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] res_r;
    logic [3:0]  flags_r;
    logic [15:0] res_next_s;
    logic [3:0]  flags_next_s;
    cmd_e        cmd_s;
    sel_e        sel_s;
    op_e         op_s;
    logic        unused_s;

    assign cmd_s    = cmd_e'(uio_in[1:0]);
    assign sel_s    = sel_e'(uio_in[3:2]);
    assign op_s     = op_e'(ui_in[3:0]);
    assign unused_s = &{1'b0, uio_in[7:4]};

    customalu_core u_core (
        .a       (a_r),
        .b       (b_r),
        .op      (op_s),
        .res_old (res_r),
        .res     (res_next_s),
        .flags   (flags_next_s)
    );

    // Operand, result and flag registers; only EXEC touches result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            res_r   <= 16'h0000;
            flags_r <= 4'h0;
        end else if (ena) begin
            case (cmd_s)
                CMD_LOAD_A: a_r <= ui_in;
                CMD_LOAD_B: b_r <= ui_in;
                CMD_EXEC: begin
                    res_r   <= res_next_s;
                    flags_r <= flags_next_s;
                end
                CMD_NOP: begin
                    a_r <= a_r;
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    // Output byte selection from the held registers.
    always_comb begin
        uo_out = 8'h00;
        case (sel_s)
            SEL_RES_LO: uo_out = res_r[7:0];
            SEL_RES_HI: uo_out = res_r[15:8];
            SEL_A:      uo_out = a_r;
            SEL_B:      uo_out = b_r;
            default:    uo_out = 8'h00;
        endcase
    end

    assign uio_out = {flags_r, 4'h0};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_custom_alu.sv
// Self-checking bench for tt_um_custom_alu: a table of ALU vectors with a
// result/flag scoreboard, plus hand sequences for load, enable and reset.
module tb_tt_um_custom_alu;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic [3:0]  flags;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
    } exp_t;

    vec_t vecs[25];
    exp_t sb_q[$];

    tt_um_custom_alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [7:0] data);
        @(negedge clk);
        uio_in = {4'h0, 2'b00, cmd};
        ui_in  = data;
        @(posedge clk);
        #1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic read_sel(input logic [1:0] sel, output logic [7:0] val);
        uio_in[3:2] = sel;
        #1;
        val = uo_out;
        uio_in[3:2] = 2'b00;
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        logic [7:0] v;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 16'h0001, 16'h0000);
        end else begin
            e = sb_q.pop_front();
            read_sel(2'b00, v);
            chk({name, "_res_lo"}, {8'h00, v}, {8'h00, e.res[7:0]});
            read_sel(2'b01, v);
            chk({name, "_res_hi"}, {8'h00, v}, {8'h00, e.res[15:8]});
            chk({name, "_flags"}, {8'h00, uio_out}, {8'h00, e.flags, 4'h0});
        end
    endtask

    task automatic exec(input string name, input logic [3:0] op,
                        input logic [15:0] res, input logic [3:0] flags);
        exp_t e;
        e.res   = res;
        e.flags = flags;
        sb_q.push_back(e);
        drive(2'b11, {4'h0, op});
        pop_check(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        checks   = 0;
        failures = 0;
        ena      = 1'b0;
        ui_in    = 8'h00;
        uio_in   = 8'h00;
        rst_n    = 1'b1;

        // ops: flags are {Z,C,N,V}
        vecs[0]  = '{4'h0, 8'h3C, 8'h05, 16'h0041, 4'b0000};
        vecs[1]  = '{4'h0, 8'hFF, 8'h01, 16'h0000, 4'b1100};
        vecs[2]  = '{4'h0, 8'h7F, 8'h01, 16'h0080, 4'b0011};
        vecs[3]  = '{4'hB, 8'h10, 8'h20, 16'h0200, 4'b0100};
        vecs[4]  = '{4'hE, 8'h55, 8'h55, 16'h0200, 4'b1000};
        vecs[5]  = '{4'h6, 8'h81, 8'h00, 16'h0002, 4'b0100};
        vecs[6]  = '{4'hA, 8'h81, 8'h00, 16'h00C0, 4'b0110};
        vecs[7]  = '{4'h8, 8'h81, 8'h00, 16'h00C0, 4'b0110};
        vecs[8]  = '{4'h1, 8'h00, 8'h01, 16'h00FF, 4'b0110};
        vecs[9]  = '{4'h1, 8'h80, 8'h01, 16'h007F, 4'b0001};
        vecs[10] = '{4'h2, 8'hF0, 8'h3C, 16'h0030, 4'b0000};
        vecs[11] = '{4'h3, 8'hF0, 8'h0F, 16'h00FF, 4'b0010};
        vecs[12] = '{4'h4, 8'hAA, 8'hAA, 16'h0000, 4'b1000};
        vecs[13] = '{4'h5, 8'h0F, 8'h00, 16'h00F0, 4'b0010};
        vecs[14] = '{4'h7, 8'h81, 8'h00, 16'h0040, 4'b0100};
        vecs[15] = '{4'h9, 8'h81, 8'h00, 16'h0003, 4'b0100};
        vecs[16] = '{4'hC, 8'hFF, 8'h00, 16'h0000, 4'b1100};
        vecs[17] = '{4'hD, 8'h00, 8'h00, 16'h00FF, 4'b0110};
        vecs[18] = '{4'hC, 8'h7F, 8'h00, 16'h0080, 4'b0011};
        vecs[19] = '{4'hD, 8'h80, 8'h00, 16'h007F, 4'b0001};
        vecs[20] = '{4'hF, 8'h12, 8'h9A, 16'h009A, 4'b0010};
        vecs[21] = '{4'hE, 8'h10, 8'h20, 16'h009A, 4'b0110};
        vecs[22] = '{4'hB, 8'hFF, 8'hFF, 16'hFE01, 4'b0110};
        vecs[23] = '{4'hB, 8'h00, 8'h55, 16'h0000, 4'b1000};
        vecs[24] = '{4'h0, 8'h01, 8'h01, 16'h0002, 4'b0000};

        // Reset is asynchronous: outputs clear before any clock edge.
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_uo_out", {8'h00, uo_out}, 16'h0000);
        chk("rst_uio_out", {8'h00, uio_out}, 16'h0000);
        chk("rst_uio_oe", {8'h00, uio_oe}, 16'h00F0);
        #17;
        rst_n = 1'b1;
        ena   = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(2'b01, vecs[i].a);
            drive(2'b10, vecs[i].b);
            read_sel(2'b10, v);
            chk($sformatf("vec%0d_rd_a", i), {8'h00, v}, {8'h00, vecs[i].a});
            read_sel(2'b11, v);
            chk($sformatf("vec%0d_rd_b", i), {8'h00, v}, {8'h00, vecs[i].b});
            exec($sformatf("vec%0d_op%0h", i, vecs[i].op), vecs[i].op,
                 vecs[i].res, vecs[i].flags);
        end

        // Result latency and loads leaving RES/flags alone.
        do_reset();
        drive(2'b01, 8'hFF);
        drive(2'b10, 8'h01);
        @(negedge clk);
        uio_in = 8'h03;
        ui_in  = 8'h00;
        #1;
        chk("lat_before_edge_flags", {8'h00, uio_out}, 16'h0000);
        read_sel(2'b00, v);
        uio_in[1:0] = 2'b11;
        chk("lat_before_edge_res", {8'h00, v}, 16'h0000);
        @(posedge clk);
        #1;
        uio_in = 8'h00;
        chk("lat_after_edge_flags", {8'h00, uio_out}, 16'h00C0);
        drive(2'b01, 8'h05);
        drive(2'b10, 8'h07);
        chk("load_keeps_flags", {8'h00, uio_out}, 16'h00C0);
        read_sel(2'b00, v);
        chk("load_keeps_res", {8'h00, v}, 16'h0000);
        read_sel(2'b10, v);
        chk("load_new_a", {8'h00, v}, 16'h0005);
        exec("after_load_add", 4'h0, 16'h000C, 4'b0000);

        // ena=0 freezes every register whatever the command.
        do_reset();
        drive(2'b01, 8'h11);
        drive(2'b10, 8'h22);
        ena = 1'b0;
        drive(2'b01, 8'hAA);
        drive(2'b10, 8'hBB);
        drive(2'b11, 8'h00);
        read_sel(2'b10, v);
        chk("ena0_a_held", {8'h00, v}, 16'h0011);
        read_sel(2'b11, v);
        chk("ena0_b_held", {8'h00, v}, 16'h0022);
        read_sel(2'b00, v);
        chk("ena0_res_held", {8'h00, v}, 16'h0000);
        chk("ena0_flags_held", {8'h00, uio_out}, 16'h0000);
        ena = 1'b1;
        exec("ena1_add", 4'h0, 16'h0033, 4'b0000);

        // Reset mid-sequence clears everything immediately.
        do_reset();
        drive(2'b01, 8'h80);
        drive(2'b10, 8'hFF);
        exec("pre_rst_mul", 4'hB, 16'h7F80, 4'b0100);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        read_sel(2'b00, v);
        chk("midrst_res_lo", {8'h00, v}, 16'h0000);
        read_sel(2'b01, v);
        chk("midrst_res_hi", {8'h00, v}, 16'h0000);
        read_sel(2'b10, v);
        chk("midrst_a", {8'h00, v}, 16'h0000);
        chk("midrst_flags", {8'h00, uio_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        read_sel(2'b11, v);
        chk("midrst_b", {8'h00, v}, 16'h0000);
        exec("post_rst_add", 4'h0, 16'h0000, 4'b1000);

        chk("sb_drained", 16'(sb_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
